// File: rtl/stream_frame_sched.sv
// Read-side frame scheduler for the LPC stream FIFO.
// Tracks FIFO occupancy and issues uninterrupted bursts of FRAME_LEN pops on request.
// It also emits sof/eof markers aligned to the FIFO's registered output and flags overflow.
// Optional statistics outputs are built when STREAM_FRAME_SCHED_STATS_EN is defined.
// Otherwise frame_cnt and max_level are tied to 0.
module stream_frame_sched #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned PTR_W     = 8,
  parameter int unsigned FRAME_LEN = 160,
  parameter int unsigned GAP_CYC   = 0,
  parameter int unsigned OUT_LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             source_v_in,
  input  logic             frame_req,
  output logic             sink_v_out,
  output logic             sof,
  output logic             eof,
  output logic             busy,
  output logic [PTR_W:0]   level,
  output logic             overflow,
  input  logic             clr_ovf,
  output logic [15:0]      frame_cnt,
  output logic [15:0]      max_level
);

  typedef enum logic [1:0] {StIdle, StBurst, StGap} state_e;

  localparam int unsigned      CntW       = PTR_W + 1;
  localparam logic [CntW-1:0]  CntLast    = CntW'(FRAME_LEN - 1);
  localparam logic [CntW-1:0]  LevelFull  = CntW'(DEPTH);
  localparam logic [CntW-1:0]  LevelFrame = CntW'(FRAME_LEN);
  localparam logic [7:0]       GapLast    = (GAP_CYC > 0) ? 8'(GAP_CYC - 1) : 8'd0;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [7:0]          gap_q, gap_d;
  logic [CntW-1:0]     level_q, level_d;
  logic                req_q, req_d;
  logic                ovf_q, ovf_d;
  logic [OUT_LAT-1:0]  sof_q, sof_d;
  logic [OUT_LAT-1:0]  eof_q, eof_d;
  logic                start, pop, first_pop, last_pop, ovf_evt;

  // Next-state logic for the burst FSM and its counters.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    start   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable && req_q && (level_q >= LevelFrame)) begin
          start   = 1'b1;
          state_d = StBurst;
          cnt_d   = '0;
        end
      end
      StBurst: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          gap_d   = '0;
          state_d = (GAP_CYC > 0) ? StGap : StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          gap_d   = '0;
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Occupancy, request latch, overflow and marker delay lines.
  always_comb begin
    pop       = (state_q == StBurst);
    first_pop = pop && (cnt_q == '0);
    last_pop  = pop && (cnt_q == CntLast);
    ovf_evt   = source_v_in && (level_q == LevelFull);

    level_d = level_q;
    if (source_v_in && !pop && (level_q != LevelFull)) begin
      level_d = level_q + CntW'(1);
    end else if (!source_v_in && pop) begin
      level_d = level_q - CntW'(1);
    end

    // A request arriving on the start cycle stays queued.
    req_d = frame_req | (req_q & ~start);
    // A new overflow wins over a simultaneous clear.
    ovf_d = ovf_evt | (ovf_q & ~clr_ovf);

    sof_d    = sof_q;
    eof_d    = eof_q;
    sof_d[0] = first_pop;
    eof_d[0] = last_pop;
    for (int i = 1; i < OUT_LAT; i++) begin
      sof_d[i] = sof_q[i-1];
      eof_d[i] = eof_q[i-1];
    end
  end

  // State registers; async reset also discards any in-flight markers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      gap_q   <= '0;
      level_q <= '0;
      req_q   <= 1'b0;
      ovf_q   <= 1'b0;
      sof_q   <= '0;
      eof_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      level_q <= level_d;
      req_q   <= req_d;
      ovf_q   <= ovf_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
    end
  end

  // Pop strobe is combinational from state so reset removes it immediately.
  always_comb begin
    sink_v_out = pop;
    busy       = (state_q != StIdle);
    level      = level_q;
    overflow   = ovf_q;
    sof        = sof_q[OUT_LAT-1];
    eof        = eof_q[OUT_LAT-1];
  end

`ifdef STREAM_FRAME_SCHED_STATS_EN
  logic [15:0] frame_cnt_q, max_level_q;

  // Completed-frame counter and occupancy high-water mark.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      max_level_q <= '0;
    end else begin
      if (eof) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (clr_ovf) begin
        max_level_q <= '0;
      end else if (16'(level_q) > max_level_q) begin
        max_level_q <= 16'(level_q);
      end
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign max_level = max_level_q;
`else
  assign frame_cnt = '0;
  assign max_level = '0;
`endif

endmodule

// File: tb/tb_stream_frame_sched.sv
// Directed self-checking bench for stream_frame_sched (FRAME_LEN=4, GAP_CYC=2, OUT_LAT=1, DEPTH=8).
module tb_stream_frame_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        source_v_in = 1'b0;
  logic        frame_req = 1'b0;
  logic        clr_ovf = 1'b0;
  logic        sink_v_out, sof, eof, busy, overflow;
  logic [3:0]  level;
  logic [15:0] frame_cnt, max_level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_frame_sched #(
    .DEPTH(8), .PTR_W(3), .FRAME_LEN(4), .GAP_CYC(2), .OUT_LAT(1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .source_v_in(source_v_in),
    .frame_req(frame_req), .sink_v_out(sink_v_out), .sof(sof), .eof(eof),
    .busy(busy), .level(level), .overflow(overflow), .clr_ovf(clr_ovf),
    .frame_cnt(frame_cnt), .max_level(max_level)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    step();
    rst = 1'b0;
  endtask

  task automatic write_n(input int n);
    source_v_in = 1'b1;
    repeat (n) step();
    source_v_in = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++; if (sink_v_out !== 1'b0) begin errors++; $display("FAIL reset_sink: got %b expected 0", sink_v_out); end
    checks++; if (sof !== 1'b0) begin errors++; $display("FAIL reset_sof: got %b expected 0", sof); end
    checks++; if (eof !== 1'b0) begin errors++; $display("FAIL reset_eof: got %b expected 0", eof); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [6:0] e_sink, e_sof, e_eof, e_busy;
    int el;
    e_sink = 7'b0001111;
    e_sof  = 7'b0000010;
    e_eof  = 7'b0010000;
    e_busy = 7'b0111111;
    do_reset();
    enable = 1'b1;
    write_n(4);
    checks++; if (level !== 4'd4) begin errors++; $display("FAIL basic_level_pre: got %0d expected 4", level); end
    frame_req = 1'b1;
    step();
    frame_req = 1'b0;
    checks++; if (sink_v_out !== 1'b0) begin errors++; $display("FAIL basic_early_pop: got %b expected 0", sink_v_out); end
    step();
    for (int i = 0; i < 7; i++) begin
      el = (i < 4) ? 4 - i : 0;
      checks++; if (sink_v_out !== e_sink[i]) begin errors++; $display("FAIL basic_sink[%0d]: got %b expected %b", i, sink_v_out, e_sink[i]); end
      checks++; if (sof !== e_sof[i]) begin errors++; $display("FAIL basic_sof[%0d]: got %b expected %b", i, sof, e_sof[i]); end
      checks++; if (eof !== e_eof[i]) begin errors++; $display("FAIL basic_eof[%0d]: got %b expected %b", i, eof, e_eof[i]); end
      checks++; if (busy !== e_busy[i]) begin errors++; $display("FAIL basic_busy[%0d]: got %b expected %b", i, busy, e_busy[i]); end
      checks++; if (level !== 4'(el)) begin errors++; $display("FAIL basic_level[%0d]: got %0d expected %0d", i, level, el); end
      step();
    end
  endtask

  task automatic test_insufficient();
    do_reset();
    enable = 1'b1;
    write_n(3);
    checks++; if (level !== 4'd3) begin errors++; $display("FAIL insuf_level3: got %0d expected 3", level); end
    frame_req = 1'b1;
    step();
    frame_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (sink_v_out !== 1'b0) begin errors++; $display("FAIL insuf_no_pop[%0d]: got %b expected 0", i, sink_v_out); end
      step();
    end
    write_n(1);
    checks++; if (level !== 4'd4) begin errors++; $display("FAIL insuf_level4: got %0d expected 4", level); end
    checks++; if (sink_v_out !== 1'b0) begin errors++; $display("FAIL insuf_pop_same_cycle: got %b expected 0", sink_v_out); end
    step();
    checks++; if (sink_v_out !== 1'b1) begin errors++; $display("FAIL insuf_burst_start: got %b expected 1", sink_v_out); end
    repeat (6) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL insuf_idle: got %b expected 0", busy); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL insuf_drained: got %0d expected 0", level); end
  endtask

  task automatic test_simul_wr_pop();
    do_reset();
    enable = 1'b1;
    write_n(4);
    frame_req = 1'b1;
    step();
    frame_req = 1'b0;
    step();
    source_v_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (sink_v_out !== 1'b1) begin errors++; $display("FAIL simul_sink[%0d]: got %b expected 1", i, sink_v_out); end
      checks++; if (level !== 4'd4) begin errors++; $display("FAIL simul_level[%0d]: got %0d expected 4", i, level); end
      step();
    end
    checks++; if (sink_v_out !== 1'b0) begin errors++; $display("FAIL simul_sink_end: got %b expected 0", sink_v_out); end
    checks++; if (level !== 4'd4) begin errors++; $display("FAIL simul_level_end: got %0d expected 4", level); end
    step();
    source_v_in = 1'b0;
    checks++; if (level !== 4'd5) begin errors++; $display("FAIL simul_level_inc: got %0d expected 5", level); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL simul_idle: got %b expected 0", busy); end
  endtask

  task automatic test_overflow();
    do_reset();
    enable = 1'b0;
    write_n(8);
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL ovf_level_full: got %0d expected 8", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", overflow); end
    write_n(1);
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL ovf_level_sat: got %0d expected 8", level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL ovf_level_after_clr: got %0d expected 8", level); end
    source_v_in = 1'b1;
    clr_ovf = 1'b1;
    step();
    source_v_in = 1'b0;
    clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_beats_clr: got %b expected 1", overflow); end
  endtask

  task automatic test_enable_reset();
    do_reset();
    enable = 1'b1;
    write_n(4);
    frame_req = 1'b1;
    step();
    frame_req = 1'b0;
    step();
    checks++; if (sink_v_out !== 1'b1) begin errors++; $display("FAIL en_first_pop: got %b expected 1", sink_v_out); end
    step();
    enable = 1'b0;
    for (int i = 1; i < 4; i++) begin
      checks++; if (sink_v_out !== 1'b1) begin errors++; $display("FAIL en_pop[%0d]: got %b expected 1", i, sink_v_out); end
      step();
    end
    checks++; if (sink_v_out !== 1'b0) begin errors++; $display("FAIL en_burst_end: got %b expected 0", sink_v_out); end
    repeat (2) step();
    write_n(4);
    frame_req = 1'b1;
    step();
    frame_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (sink_v_out !== 1'b0) begin errors++; $display("FAIL en_blocked[%0d]: got %b expected 0", i, sink_v_out); end
      step();
    end
    enable = 1'b1;
    step();
    checks++; if (sink_v_out !== 1'b1) begin errors++; $display("FAIL en_resume: got %b expected 1", sink_v_out); end
    step();
    checks++; if (sof !== 1'b1) begin errors++; $display("FAIL en_resume_sof: got %b expected 1", sof); end
    step();
    checks++; if (level !== 4'd2) begin errors++; $display("FAIL en_level_3rd_pop: got %0d expected 2", level); end
    rst = 1'b1;
    #1;
    checks++; if (sink_v_out !== 1'b0) begin errors++; $display("FAIL rst_sink: got %b expected 0", sink_v_out); end
    checks++; if (sof !== 1'b0) begin errors++; $display("FAIL rst_sof: got %b expected 0", sof); end
    checks++; if (eof !== 1'b0) begin errors++; $display("FAIL rst_eof: got %b expected 0", eof); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL rst_level: got %0d expected 0", level); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    // In-flight sof marker must be discarded by reset.
    step();
    rst = 1'b0;
    write_n(4);
    frame_req = 1'b1;
    step();
    frame_req = 1'b0;
    step();
    step();
    checks++; if (sof !== 1'b1) begin errors++; $display("FAIL rst2_sof_pre: got %b expected 1", sof); end
    rst = 1'b1;
    #1;
    checks++; if (sof !== 1'b0) begin errors++; $display("FAIL rst2_sof: got %b expected 0", sof); end
    step();
    rst = 1'b0;
    // In-flight eof marker must be discarded by reset.
    write_n(4);
    frame_req = 1'b1;
    step();
    frame_req = 1'b0;
    repeat (5) step();
    checks++; if (eof !== 1'b1) begin errors++; $display("FAIL rst3_eof_pre: got %b expected 1", eof); end
    rst = 1'b1;
    #1;
    checks++; if (eof !== 1'b0) begin errors++; $display("FAIL rst3_eof: got %b expected 0", eof); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [13:0] e_sink;
    logic [15:0] e_cnt, e_max;
    e_sink = 14'b00011110001111;
`ifdef STREAM_FRAME_SCHED_STATS_EN
    e_cnt = 16'd2;
    e_max = 16'd8;
`else
    e_cnt = 16'd0;
    e_max = 16'd0;
`endif
    do_reset();
    enable = 1'b1;
    write_n(8);
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL b2b_level_pre: got %0d expected 8", level); end
    frame_req = 1'b1;
    step();
    frame_req = 1'b0;
    step();
    for (int i = 0; i < 14; i++) begin
      frame_req = (i == 0);
      checks++; if (sink_v_out !== e_sink[i]) begin errors++; $display("FAIL b2b_sink[%0d]: got %b expected %b", i, sink_v_out, e_sink[i]); end
      step();
    end
    frame_req = 1'b0;
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL b2b_level_end: got %0d expected 0", level); end
    checks++; if (frame_cnt !== e_cnt) begin errors++; $display("FAIL b2b_frame_cnt: got %0d expected %0d", frame_cnt, e_cnt); end
    checks++; if (max_level !== e_max) begin errors++; $display("FAIL b2b_max_level: got %0d expected %0d", max_level, e_max); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_insufficient();
    test_simul_wr_pop();
    test_overflow();
    test_enable_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_frame_sched.md
# stream_frame_sched

Read-side scheduler for the 256-entry stream FIFO in the LPC sample path. It tracks FIFO occupancy from the write strobes and the pops it issues itself. When a full analysis frame is buffered and the downstream LPC stage requests one, it issues an uninterrupted burst of `FRAME_LEN` pop strobes. It also emits start-of-frame and end-of-frame markers aligned to the FIFO's registered output, and flags overflow.

## Interface
Parameters:
- `DEPTH`, 256: FIFO capacity in samples.
- `PTR_W`, 8: log2(`DEPTH`).
- `FRAME_LEN`, 160: samples per frame; legal range 1..`DEPTH`.
- `GAP_CYC`, 0: idle cycles forced after each burst; legal range 0..255.
- `OUT_LAT`, 1: cycles from pop strobe to valid FIFO output; legal range 1..4.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `enable`, in, 1: permits new bursts to start.
- `source_v_in`, in, 1: FIFO write strobe, tapped in parallel with the FIFO.
- `frame_req`, in, 1: one-cycle pulse from the consumer requesting one frame.
- `sink_v_out`, out, 1: pop strobe, connected to the FIFO `sink_v_in`.
- `sof`, out, 1: high with the first valid output sample of a frame.
- `eof`, out, 1: high with the last valid output sample of a frame.
- `busy`, out, 1: high when the state is not IDLE.
- `level`, out, `PTR_W`+1: current occupancy, 0..`DEPTH`.
- `overflow`, out, 1: sticky flag, set by a write while `level`==`DEPTH`.
- `clr_ovf`, in, 1: synchronous clear for `overflow`.

## Operation
- **Reset values:**
  - All outputs are 0.
  - State is IDLE.
  - Request latch, burst counter, gap counter and the marker delay lines are all 0.
- **Occupancy (`level`):**
  - A write alone gives +1; a pop alone gives −1; a write and a pop in the same cycle give no change.
  - A write at `level`==`DEPTH` leaves `level` at `DEPTH` and sets `overflow`.
  - `clr_ovf` and a new overflow event in the same cycle: `overflow` stays set.
  - Pops are only issued in BURST, and a burst only starts with ≥`FRAME_LEN` samples, so `level` never goes below 0.
- **Request latch:**
  - Set by `frame_req`; cleared on the cycle a burst starts.
  - Further requests while it is already set are absorbed, not counted.
  - A `frame_req` in the same cycle as a burst start re-sets the latch, so the request is queued.
- **State machine:**
  - IDLE→BURST when `enable` && the latch is set && `level`≥`FRAME_LEN`, all sampled in that cycle.
  - BURST: `sink_v_out`=1 every cycle while the burst counter counts 0..`FRAME_LEN`-1.
  - BURST, on the last pop → GAP if `GAP_CYC`>0, otherwise IDLE.
  - GAP: hold for `GAP_CYC` cycles, then → IDLE.
  - Deasserting `enable` mid-burst does not abort it; frames are never split. `enable` gates only the IDLE exit.
- **Markers:**
  - Internal signals: first-pop = BURST && count==0; last-pop = BURST && count==`FRAME_LEN`-1.
  - `sof` and `eof` are those signals delayed by `OUT_LAT` registers.
  - `FRAME_LEN`==1: `sof` and `eof` are high on the same cycle.
- **Pointer wrap:** handled entirely inside the FIFO. The scheduler only counts occupancy.

## Timing
- A request sampled at edge N with the conditions met: state is BURST after edge N+1, and `sink_v_out` is high for edges N+1..N+`FRAME_LEN`.
- `sof` rises `OUT_LAT` cycles after the first `sink_v_out`; `eof` rises `OUT_LAT` cycles after the last one.
- Minimum spacing between burst starts is `FRAME_LEN`+`GAP_CYC`+1 cycles (one IDLE cycle).
- `level` is registered and reflects writes and pops from the previous edge.
- Asserting `rst` mid-burst: `sink_v_out` drops immediately (asynchronously), any in-flight markers are discarded, and `level` goes to 0. The FIFO must be reset together with this block.

## Configuration
- Macro: `STREAM_FRAME_SCHED_STATS_EN`.
- **Defined:** adds two 16-bit outputs, reset to 0.
  - `frame_cnt`: increments on every `eof`; wraps from 65535 to 0.
  - `max_level`: high-water mark of `level`; cleared by `clr_ovf`.
- **Undefined:** both ports still exist but are tied to 0, and no counters are synthesized. All other behaviour is identical.

## Test plan
Bench configuration for all scenarios: `FRAME_LEN`=4, `GAP_CYC`=2, `OUT_LAT`=1, `DEPTH`=8.
- **Basic burst:** write 4 samples, then pulse `frame_req` with `enable`=1 → `sink_v_out` is high for exactly 4 consecutive cycles; `sof` on the cycle after the first pop; `eof` 3 cycles after `sof`; `level` goes 4→0; `busy` is high for 6 cycles.
- **Insufficient data:** `level`=3, pulse `frame_req` → no pop. One more write → burst starts 1 cycle after `level`=4 is visible.
- **Simultaneous write and pop:** write every cycle during the burst starting from `level`=4 → `level` holds at 4 throughout the burst, then increments.
- **Overflow:** 9 writes with no pops → `level`=8 and `overflow`=1; `clr_ovf` → `overflow`=0 and `level` is still 8.
- **Enable drop and reset mid-operation:**
  - Drop `enable` at the 2nd pop → all 4 pops complete, and no new burst starts while `enable`=0.
  - Assert `rst` at the 3rd pop → `sink_v_out`, `sof`, `eof` and `level` go to 0 with no clock edge required.
- **Back-to-back requests:** `level`=8, two `frame_req` pulses 1 cycle apart → two bursts with exactly 3 non-pop cycles between them (2 GAP cycles + 1 IDLE); with the stats macro defined, `frame_cnt`=2.
